ring_decoder: RTL and testbench

- Receive-side checker/decoder for the 6-bit one-hot rotating code produced by the team's ring counter.
- Samples the ring word, converts it to a binary index, and checks both one-hot validity and the rotate-left sequence (bit WIDTH-1 wraps to bit 0).
- Maintains a lock state machine and a saturating error counter.
- Sits at the consumer end of any ring-counter bus, for example a phase selector or a slot scheduler.

---
 rtl/ring_pkg.sv | 15 +
 rtl/ring_decoder_if.sv | 37 +++
 rtl/onehot_to_bin.sv | 27 ++
 rtl/ring_decoder.sv | 119 +++++++++++
 tb/tb_ring_decoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared FSM states, default ring width and rotate helper for the ring decoder
package ring_pkg;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam int DEF_WIDTH = 6;

  // Rotate left within the low w bits (bit w-1 wraps to bit 0); upper bits are zeroed.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// rtl/ring_decoder_if.sv - ring decoder sample/result bundle; REV_CNT_EN adds rev_cnt
interface ring_decoder_if #(
  parameter int WIDTH = 6,
  parameter int ERR_W = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] ring_in;
  logic             ring_vld;
  logic             err_clr;
  logic [IDX_W-1:0] index;
  logic             index_vld;
  logic             onehot_err;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;
`ifdef REV_CNT_EN
  logic [15:0]      rev_cnt;
`endif

  modport master (
    output ring_in, ring_vld, err_clr,
    input  index, index_vld, onehot_err, seq_err, locked, err_cnt
`ifdef REV_CNT_EN
    , input rev_cnt
`endif
  );

  modport slave (
    input  ring_in, ring_vld, err_clr,
    output index, index_vld, onehot_err, seq_err, locked, err_cnt
`ifdef REV_CNT_EN
    , output rev_cnt
`endif
  );

endinterface

// File: rtl/onehot_to_bin.sv
// rtl/onehot_to_bin.sv - combinational one-hot validity flag and set-bit index
module onehot_to_bin #(
  parameter int WIDTH = 6,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             onehot,
  output logic [IDX_W-1:0] idx
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;

  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        cnt = cnt + 1'b1;
        idx = IDX_W'(i);
      end
    end
    onehot = (cnt == CW'(1));
  end

endmodule

// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - one-hot ring word checker with lock FSM and saturating error count
// Optional REV_CNT_EN: revolution counter output rev_cnt while locked.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  ring_decoder_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GW    = $clog2(LOCK_N + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] ref_q, ref_nx, expected;
  logic [GW-1:0]    good_q, good_nx, good_inc;
  logic [IDX_W-1:0] idx, index_nx;
  logic             oh, match;
  logic             vld_nx, oherr_nx, seqerr_nx;

  onehot_to_bin #(.WIDTH(WIDTH)) u_o2b (
    .vec    (bus.ring_in),
    .onehot (oh),
    .idx    (idx)
  );

  assign expected = WIDTH'(rotl(32'(ref_q), WIDTH));
  assign match    = (bus.ring_in == expected);
  assign good_inc = good_q + 1'b1;

  always_comb begin
    state_nx  = state;
    ref_nx    = ref_q;
    good_nx   = good_q;
    index_nx  = bus.index;
    vld_nx    = 1'b0;
    oherr_nx  = 1'b0;
    seqerr_nx = 1'b0;
    if (bus.ring_vld) begin
      if (!oh) begin
        oherr_nx = 1'b1;
        state_nx = SEARCH;
        ref_nx   = '0;
        good_nx  = '0;
      end else begin
        vld_nx   = 1'b1;
        index_nx = idx;
        ref_nx   = bus.ring_in;
        case (state)
          SEARCH: begin
            state_nx = TRACK;
            good_nx  = '0;
          end
          TRACK: begin
            if (match) begin
              good_nx = good_inc;
              if (good_inc == GW'(LOCK_N)) state_nx = LOCKED;
            end else begin
              seqerr_nx = 1'b1;
              good_nx   = '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              seqerr_nx = 1'b1;
              state_nx  = TRACK;
              good_nx   = '0;
            end
          end
          default: state_nx = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= SEARCH;
      ref_q          <= '0;
      good_q         <= '0;
      bus.index      <= '0;
      bus.index_vld  <= 1'b0;
      bus.onehot_err <= 1'b0;
      bus.seq_err    <= 1'b0;
      bus.locked     <= 1'b0;
      bus.err_cnt    <= '0;
    end else begin
      state          <= state_nx;
      ref_q          <= ref_nx;
      good_q         <= good_nx;
      bus.index      <= index_nx;
      bus.index_vld  <= vld_nx;
      bus.onehot_err <= oherr_nx;
      bus.seq_err    <= seqerr_nx;
      bus.locked     <= (state_nx == LOCKED);
      // Clear wins over a same-cycle error; the error pulse itself still goes out.
      if (bus.err_clr)
        bus.err_cnt <= '0;
      else if ((oherr_nx || seqerr_nx) && (bus.err_cnt != {ERR_W{1'b1}}))
        bus.err_cnt <= bus.err_cnt + 1'b1;
    end
  end

`ifdef REV_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus.rev_cnt <= '0;
    else if (state_nx != LOCKED)
      bus.rev_cnt <= '0;
    else if (state == LOCKED && bus.ring_vld && oh && match && ref_q[WIDTH-1])
      bus.rev_cnt <= bus.rev_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// tb/tb_ring_decoder.sv - directed self-checking bench for ring_decoder
module tb_ring_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ring_decoder_if #(.WIDTH(6), .ERR_W(8)) b1 ();
  ring_decoder_if #(.WIDTH(6), .ERR_W(2)) b2 ();

  ring_decoder #(.WIDTH(6), .LOCK_N(4), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(b1));
  ring_decoder #(.WIDTH(6), .LOCK_N(4), .ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  // {index_vld, index, onehot_err, seq_err, locked, err_cnt}
  function automatic logic [14:0] ex(input bit v, input int i, input bit o, input bit s,
                                     input bit l, input int c);
    return {v, 3'(i), o, s, l, 8'(c)};
  endfunction

  function automatic logic [14:0] obs1();
    return {b1.index_vld, b1.index, b1.onehot_err, b1.seq_err, b1.locked, b1.err_cnt};
  endfunction

  task automatic step1(input logic [5:0] w, input logic v);
    b1.ring_in  = w;
    b1.ring_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic [5:0] w, input logic v, input logic clr);
    b2.ring_in  = w;
    b2.ring_vld = v;
    b2.err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs1() !== 15'd0) begin
      errors++;
      $display("FAIL reset got %h want %h", obs1(), 15'd0);
    end
    checks++;
    if (b2.err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset2 got %0d want 0", b2.err_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_rotation();
    logic [14:0] e;
    for (int i = 0; i < 6; i++) begin
      step1(6'(1 << i), 1'b1);
      e = ex(1, i, 0, 0, i >= 4, 0);
      checks++;
      if (obs1() !== e) begin
        errors++;
        $display("FAIL rotation[%0d] got %h want %h", i, obs1(), e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [14:0] e;
    for (int k = 0; k < 7; k++) begin
      step1(6'(1 << (k % 6)), 1'b1);
      e = ex(1, k % 6, 0, 0, 1, 0);
      checks++;
      if (obs1() !== e) begin
        errors++;
        $display("FAIL wrap[%0d] got %h want %h", k, obs1(), e);
      end
    end
  endtask

  task automatic test_skip();
    logic [5:0]  w [3] = '{6'b000010, 6'b000100, 6'b010000};
    logic [14:0] e [3];
    e = '{ex(1, 1, 0, 0, 1, 0), ex(1, 2, 0, 0, 1, 0), ex(1, 4, 0, 1, 0, 1)};
    for (int k = 0; k < 3; k++) begin
      step1(w[k], 1'b1);
      checks++;
      if (obs1() !== e[k]) begin
        errors++;
        $display("FAIL skip[%0d] got %h want %h", k, obs1(), e[k]);
      end
    end
  endtask

  task automatic test_bad_word();
    logic [5:0]  w [7] = '{6'b100000, 6'b000001, 6'b000010, 6'b000100,
                           6'b000110, 6'b000000, 6'b001000};
    logic [14:0] e [7];
    e = '{ex(1, 5, 0, 0, 0, 1), ex(1, 0, 0, 0, 0, 1), ex(1, 1, 0, 0, 0, 1),
          ex(1, 2, 0, 0, 1, 1), ex(0, 2, 1, 0, 0, 2), ex(0, 2, 1, 0, 0, 3),
          ex(1, 3, 0, 0, 0, 3)};
    for (int k = 0; k < 7; k++) begin
      step1(w[k], 1'b1);
      checks++;
      if (obs1() !== e[k]) begin
        errors++;
        $display("FAIL bad_word[%0d] got %h want %h", k, obs1(), e[k]);
      end
    end
  endtask

  task automatic test_stall();
    logic [5:0]  w [4] = '{6'b010000, 6'b100000, 6'b000001, 6'b000010};
    logic [14:0] e [4];
    e = '{ex(1, 4, 0, 0, 0, 3), ex(1, 5, 0, 0, 0, 3), ex(1, 0, 0, 0, 0, 3),
          ex(1, 1, 0, 0, 1, 3)};
    for (int k = 0; k < 10; k++) begin
      step1(6'b000110, 1'b0);
      checks++;
      if (obs1() !== ex(0, 3, 0, 0, 0, 3)) begin
        errors++;
        $display("FAIL stall_track[%0d] got %h want %h", k, obs1(), ex(0, 3, 0, 0, 0, 3));
      end
    end
    for (int k = 0; k < 4; k++) begin
      step1(w[k], 1'b1);
      checks++;
      if (obs1() !== e[k]) begin
        errors++;
        $display("FAIL stall_resume[%0d] got %h want %h", k, obs1(), e[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step1(6'b100001, 1'b0);
      checks++;
      if (obs1() !== ex(0, 1, 0, 0, 1, 3)) begin
        errors++;
        $display("FAIL stall_locked[%0d] got %h want %h", k, obs1(), ex(0, 1, 0, 0, 1, 3));
      end
    end
    step1(6'b000100, 1'b1);
    checks++;
    if (obs1() !== ex(1, 2, 0, 0, 1, 3)) begin
      errors++;
      $display("FAIL stall_after got %h want %h", obs1(), ex(1, 2, 0, 0, 1, 3));
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0]  w [5] = '{6'b001000, 6'b010000, 6'b100000, 6'b000001, 6'b000010};
    logic [14:0] e [5];
    e = '{ex(1, 3, 0, 0, 0, 0), ex(1, 4, 0, 0, 0, 0), ex(1, 5, 0, 0, 0, 0),
          ex(1, 0, 0, 0, 0, 0), ex(1, 1, 0, 0, 1, 0)};
    b1.ring_in  = 6'b001000;
    b1.ring_vld = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #2;
    checks++;
    if (obs1() !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid got %h want %h", obs1(), 15'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step1(w[k], 1'b1);
      checks++;
      if (obs1() !== e[k]) begin
        errors++;
        $display("FAIL relock[%0d] got %h want %h", k, obs1(), e[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [5:0] w [4]   = '{6'b000011, 6'b000001, 6'b000100, 6'b010000};
    logic       clr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] e [4]   = '{{1'b1, 1'b0, 2'd0}, {1'b0, 1'b0, 2'd0},
                            {1'b0, 1'b1, 2'd1}, {1'b0, 1'b1, 2'd0}};
    for (int k = 0; k < 5; k++) begin
      step2(6'b000000, 1'b1, 1'b0);
      checks++;
      if ({b2.onehot_err, b2.err_cnt} !== {1'b1, 2'((k >= 2) ? 3 : k + 1)}) begin
        errors++;
        $display("FAIL saturate[%0d] got oh=%b cnt=%0d want oh=1 cnt=%0d",
                 k, b2.onehot_err, b2.err_cnt, (k >= 2) ? 3 : k + 1);
      end
    end
    // {onehot_err, seq_err, err_cnt}
    for (int k = 0; k < 4; k++) begin
      step2(w[k], 1'b1, clr[k]);
      checks++;
      if ({b2.onehot_err, b2.seq_err, b2.err_cnt} !== e[k]) begin
        errors++;
        $display("FAIL err_clr[%0d] got %b want %b", k,
                 {b2.onehot_err, b2.seq_err, b2.err_cnt}, e[k]);
      end
    end
    b2.err_clr = 1'b0;
  endtask

  initial begin
    b1.ring_in = '0; b1.ring_vld = 1'b0; b1.err_clr = 1'b0;
    b2.ring_in = '0; b2.ring_vld = 1'b0; b2.err_clr = 1'b0;
    test_reset();
    test_rotation();
    test_wrap();
    test_skip();
    test_bad_word();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
